disp_sched: RTL and testbench

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_sched.sv | 148 ++++++++++++++
 tb/tb_disp_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// disp_sched: four requesters share one iterative subtract-by-10
// binary-to-BCD converter under round-robin arbitration.
// Optional 7-segment outputs are compiled in with DISP_SCHED_SEG_EN.
module disp_sched #(
  parameter int WIDTH = 6
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] VAL,
  output logic [3:0]         ACK,
  output logic [3:0]         TENS,
  output logic [3:0]         ONES,
  output logic               BUSY
`ifdef DISP_SCHED_SEG_EN
  ,
  output logic [0:6]         HEX1,
  output logic [0:6]         HEX0
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_ptr, w_ptr_next;
  logic [1:0]         r_g, w_g_next;
  logic [WIDTH-1:0]   r_rem, w_rem_next;
  logic [3:0]         r_tacc, w_tacc_next;
  logic [3:0]         r_tens, w_tens_next;
  logic [3:0]         r_ones, w_ones_next;

  logic [WIDTH-1:0]   w_val [4];
  logic               w_any;
  logic [1:0]         w_gidx;

  // Unpack the per-requester values
  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign w_val[gi] = VAL[WIDTH*gi +: WIDTH];
  end

  // Round-robin pick: first active requester at or after the pointer
  always_comb begin
    logic [1:0] v_idx;
    v_idx  = r_ptr;
    w_any  = 1'b0;
    w_gidx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      v_idx = r_ptr + 2'(k);
      if (REQ[v_idx]) begin
        w_any  = 1'b1;
        w_gidx = v_idx;
      end
    end
  end

  // Next-state and ACK decode
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_g_next     = r_g;
    w_rem_next   = r_rem;
    w_tacc_next  = r_tacc;
    w_tens_next  = r_tens;
    w_ones_next  = r_ones;
    ACK          = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_g_next     = w_gidx;
          w_rem_next   = w_val[w_gidx];
          w_tacc_next  = 4'd0;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (r_rem >= WIDTH'(10)) begin
          w_rem_next  = r_rem - WIDTH'(10);
          w_tacc_next = r_tacc + 4'd1;
        end else begin
          w_tens_next  = r_tacc;
          w_ones_next  = r_rem[3:0];
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        ACK          = 4'b0001 << r_g;
        w_ptr_next   = r_g + 2'd1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_g     <= 2'd0;
      r_rem   <= '0;
      r_tacc  <= 4'd0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_g     <= w_g_next;
      r_rem   <= w_rem_next;
      r_tacc  <= w_tacc_next;
      r_tens  <= w_tens_next;
      r_ones  <= w_ones_next;
    end
  end

  assign TENS = r_tens;
  assign ONES = r_ones;
  assign BUSY = (r_state != S_IDLE);

`ifdef DISP_SCHED_SEG_EN
  // Active-low a..g patterns; values above 9 blank the digit
  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Decode the registered digits
  always_comb begin
    HEX1 = seg7(r_tens);
    HEX0 = seg7(r_ones);
  end
`endif

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched; HEX checks compile in with DISP_SCHED_SEG_EN.
`timescale 1ns/1ps
module tb_disp_sched;
  localparam int W = 6;

  logic           Clock = 1'b0;
  logic           Resetn = 1'b0;
  logic [3:0]     REQ = 4'b0000;
  logic [4*W-1:0] VAL = '0;
  logic [3:0]     ACK, TENS, ONES;
  logic           BUSY;
`ifdef DISP_SCHED_SEG_EN
  logic [0:6]     HEX1, HEX0;
`endif

  int vecs = 0;
  int errs = 0;

  disp_sched #(.WIDTH(W)) dut (
    .Clock(Clock), .Resetn(Resetn), .REQ(REQ), .VAL(VAL),
    .ACK(ACK), .TENS(TENS), .ONES(ONES), .BUSY(BUSY)
`ifdef DISP_SCHED_SEG_EN
    , .HEX1(HEX1), .HEX0(HEX0)
`endif
  );

  always #5 Clock = ~Clock;

  function automatic logic [4*W-1:0] pack(input int a, input int b, input int c, input int d);
    pack = {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    tick(); tick();
    Resetn = 1'b1;
  endtask

  // Measure one transaction: lat counts cycles from the grant (cycle 1) to ACK.
  // Optionally rewrite REQ/VAL in the cycle right after the grant.
  task automatic serve(input logic mid_en, input logic [3:0] mid_req, input logic [4*W-1:0] mid_val,
                       output int lat, output logic [3:0] ack, output logic [3:0] t,
                       output logic [3:0] o, output logic busy_ok);
    int n;
    lat = -1; ack = 4'b0; t = 4'b0; o = 4'b0; busy_ok = 1'b1; n = 0;
    do begin tick(); n++; end while (!BUSY && n < 20);
    if (!BUSY) return;
    lat = 1;
    if (mid_en) begin REQ = mid_req; VAL = mid_val; end
    while (ACK == 4'b0 && lat < 20) begin
      tick(); lat++;
      if (!BUSY) busy_ok = 1'b0;
    end
    if (ACK == 4'b0) begin lat = -1; return; end
    ack = ACK; t = TENS; o = ONES;
    $display("txn ack=%b lat=%0d tens=%0d ones=%0d", ack, lat, t, o);
  endtask

  task automatic test_reset();
    Resetn = 1'b0; REQ = 4'b0; VAL = '0;
    #3;
    vecs++; if (ACK !== 4'b0)  begin errs++; $display("FAIL reset_ack got %b want 0000", ACK); end
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", BUSY); end
    vecs++; if (TENS !== 4'd0) begin errs++; $display("FAIL reset_tens got %0d want 0", TENS); end
    vecs++; if (ONES !== 4'd0) begin errs++; $display("FAIL reset_ones got %0d want 0", ONES); end
`ifdef DISP_SCHED_SEG_EN
    vecs++; if (HEX1 !== 7'b0000001) begin errs++; $display("FAIL reset_hex1 got %b want 0000001", HEX1); end
    vecs++; if (HEX0 !== 7'b0000001) begin errs++; $display("FAIL reset_hex0 got %b want 0000001", HEX0); end
`endif
    tick(); tick();
    Resetn = 1'b1;
    tick(); tick();
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL idle_busy got %b want 0", BUSY); end
  endtask

  task automatic test_single();
    int lat; logic [3:0] a, t, o; logic bok;
    VAL = pack(47, 0, 0, 0); REQ = 4'b0001;
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    REQ = 4'b0000;
    vecs++; if (a !== 4'b0001) begin errs++; $display("FAIL single_ack got %b want 0001", a); end
    vecs++; if (lat !== 6)     begin errs++; $display("FAIL single_lat got %0d want 6", lat); end
    vecs++; if (t !== 4'd4)    begin errs++; $display("FAIL single_tens got %0d want 4", t); end
    vecs++; if (o !== 4'd7)    begin errs++; $display("FAIL single_ones got %0d want 7", o); end
    vecs++; if (bok !== 1'b1)  begin errs++; $display("FAIL single_busy got %b want 1", bok); end
    tick();
    vecs++; if (ACK !== 4'b0)  begin errs++; $display("FAIL single_ack_pulse got %b want 0000", ACK); end
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL single_busy_after got %b want 0", BUSY); end
    tick(); tick();
    vecs++; if (TENS !== 4'd4 || ONES !== 4'd7)
      begin errs++; $display("FAIL single_hold got %0d/%0d want 4/7", TENS, ONES); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] a, t, o; logic bok;
    int e_lat [4] = '{2, 3, 8, 8};
    int e_t   [4] = '{0, 1, 6, 6};
    int e_o   [4] = '{5, 9, 0, 3};
    do_reset();
    VAL = pack(5, 19, 60, 63); REQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
      REQ = REQ & ~a;
      vecs++; if (a !== (4'b0001 << i)) begin errs++; $display("FAIL rr_ack%0d got %b want %b", i, a, 4'b0001 << i); end
      vecs++; if (lat !== e_lat[i]) begin errs++; $display("FAIL rr_lat%0d got %0d want %0d", i, lat, e_lat[i]); end
      vecs++; if (t !== 4'(e_t[i]) || o !== 4'(e_o[i]))
        begin errs++; $display("FAIL rr_val%0d got %0d/%0d want %0d/%0d", i, t, o, e_t[i], e_o[i]); end
    end
    REQ = 4'b0;
  endtask

  task automatic test_wrap();
    int lat; logic [3:0] a, t, o; logic bok;
    do_reset();
    VAL = pack(8, 0, 25, 0); REQ = 4'b0100;
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    vecs++; if (a !== 4'b0100) begin errs++; $display("FAIL wrap_first got %b want 0100", a); end
    VAL = pack(8, 0, 33, 0); REQ = 4'b0101;
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    REQ = REQ & ~a;
    vecs++; if (a !== 4'b0001) begin errs++; $display("FAIL wrap_second got %b want 0001", a); end
    vecs++; if (lat !== 2 || t !== 4'd0 || o !== 4'd8)
      begin errs++; $display("FAIL wrap_second_val got lat%0d %0d/%0d want lat2 0/8", lat, t, o); end
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    REQ = REQ & ~a;
    vecs++; if (a !== 4'b0100) begin errs++; $display("FAIL wrap_third got %b want 0100", a); end
    vecs++; if (lat !== 5 || t !== 4'd3 || o !== 4'd3)
      begin errs++; $display("FAIL wrap_third_val got lat%0d %0d/%0d want lat5 3/3", lat, t, o); end
  endtask

  task automatic test_val_change();
    int lat; logic [3:0] a, t, o; logic bok;
    do_reset();
    VAL = pack(9, 0, 0, 0); REQ = 4'b0001;
    // VAL0 moves to 50 and REQ drops right after the grant
    serve(1'b1, 4'b0000, pack(50, 0, 0, 0), lat, a, t, o, bok);
    vecs++; if (a !== 4'b0001) begin errs++; $display("FAIL vchg_ack got %b want 0001", a); end
    vecs++; if (lat !== 2)     begin errs++; $display("FAIL vchg_lat got %0d want 2", lat); end
    vecs++; if (t !== 4'd0 || o !== 4'd9)
      begin errs++; $display("FAIL vchg_val got %0d/%0d want 0/9", t, o); end
    tick(); tick();
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL vchg_no_regrant got %b want 0", BUSY); end
  endtask

  task automatic test_reset_mid();
    int lat; int n; logic [3:0] a, t, o; logic bok;
    // pointer is 1 here; ONES still holds 9
    VAL = pack(0, 12, 0, 63); REQ = 4'b1000;
    n = 0;
    do begin tick(); n++; end while (!BUSY && n < 20);
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL rmid_grant got %b want 1", BUSY); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (ACK !== 4'b0) begin errs++; $display("FAIL rmid_early_ack got %b want 0000", ACK); end
    end
    Resetn = 1'b0;
    #1;
    vecs++; if (ACK !== 4'b0 || BUSY !== 1'b0 || TENS !== 4'd0 || ONES !== 4'd0)
      begin errs++; $display("FAIL rmid_async got ack%b busy%b %0d/%0d want all 0", ACK, BUSY, TENS, ONES); end
    tick(); tick();
    REQ = 4'b1010;
    Resetn = 1'b1;
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    REQ = REQ & ~a;
    vecs++; if (a !== 4'b0010) begin errs++; $display("FAIL rmid_restart got %b want 0010", a); end
    vecs++; if (lat !== 3 || t !== 4'd1 || o !== 4'd2)
      begin errs++; $display("FAIL rmid_restart_val got lat%0d %0d/%0d want lat3 1/2", lat, t, o); end
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    REQ = REQ & ~a;
    vecs++; if (a !== 4'b1000 || lat !== 8 || t !== 4'd6 || o !== 4'd3)
      begin errs++; $display("FAIL rmid_next got %b lat%0d %0d/%0d want 1000 lat8 6/3", a, lat, t, o); end
  endtask

`ifdef DISP_SCHED_SEG_EN
  task automatic test_seg();
    int lat; logic [3:0] a, t, o; logic bok;
    do_reset();
    vecs++; if (HEX1 !== 7'b0000001 || HEX0 !== 7'b0000001)
      begin errs++; $display("FAIL seg_reset got %b/%b want 0000001/0000001", HEX1, HEX0); end
    VAL = pack(10, 0, 0, 0); REQ = 4'b0001;
    serve(1'b0, 4'b0, '0, lat, a, t, o, bok);
    REQ = 4'b0;
    vecs++; if (HEX1 !== 7'b1001111) begin errs++; $display("FAIL seg_hex1 got %b want 1001111", HEX1); end
    vecs++; if (HEX0 !== 7'b0000001) begin errs++; $display("FAIL seg_hex0 got %b want 0000001", HEX0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_val_change();
    test_reset_mid();
`ifdef DISP_SCHED_SEG_EN
    test_seg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
